// File: rtl/wave_stim_pkg.sv
// -----------------------------------------------------------------------------
// wave_stim_pkg
// Shared definitions for the periodic waveform stimulus generator:
//   - waveform mode encodings (sine / square / triangle / sawtooth)
//   - FSM state encodings (IDLE / RUN / STOP)
//   - number of steps per period and the four 8-entry 16-bit waveform tables
// The tables are full-scale signed 16-bit values indexed by phase 0..7.
// -----------------------------------------------------------------------------
package wave_stim_pkg;

  localparam int STEPS   = 8;
  localparam int PHASE_W = 3;
  localparam int TBL_W   = 16;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SAW    = 2'd3
  } wave_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

  // Entry 0 is the leftmost element of each constant.
  localparam logic [0:STEPS-1][TBL_W-1:0] SINE_TBL = {
    16'h0000, 16'h5A7E, 16'h7FFF, 16'h5A7E,
    16'h0000, 16'hA582, 16'h8000, 16'hA582
  };

  localparam logic [0:STEPS-1][TBL_W-1:0] SQUARE_TBL = {
    16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
    16'h8000, 16'h8000, 16'h8000, 16'h8000
  };

  localparam logic [0:STEPS-1][TBL_W-1:0] TRI_TBL = {
    16'h0000, 16'h4000, 16'h7FFF, 16'h4000,
    16'h0000, 16'hC000, 16'h8000, 16'hC000
  };

  localparam logic [0:STEPS-1][TBL_W-1:0] SAW_TBL = {
    16'h8000, 16'hA000, 16'hC000, 16'hE000,
    16'h0000, 16'h2000, 16'h4000, 16'h6000
  };

endpackage

// File: rtl/wave_stim_lut.sv
// -----------------------------------------------------------------------------
// wave_stim_lut
// Combinational waveform lookup: (mode, phase) -> full-scale 16-bit sample.
// Ports:
//   mode_i   [1:0]  waveform select (wave_mode_e encoding)
//   phase_i  [2:0]  step within the period, 0..7
//   value_o  [15:0] signed table value
// -----------------------------------------------------------------------------
module wave_stim_lut
  import wave_stim_pkg::*;
(
  input  logic [1:0]         mode_i,
  input  logic [PHASE_W-1:0] phase_i,
  output logic [TBL_W-1:0]   value_o
);

  always_comb begin
    value_o = '0;
    case (wave_mode_e'(mode_i))
      WAVE_SINE:   value_o = SINE_TBL[phase_i];
      WAVE_SQUARE: value_o = SQUARE_TBL[phase_i];
      WAVE_TRI:    value_o = TRI_TBL[phase_i];
      WAVE_SAW:    value_o = SAW_TBL[phase_i];
      default:     value_o = '0;
    endcase
  end

endmodule

// File: rtl/wave_stim_gen.sv
// -----------------------------------------------------------------------------
// wave_stim_gen
// Periodic 8-step signed waveform source with valid/ready output handshake.
// Modes: sine, square, triangle, sawtooth. Each table value is reduced to
// DATA_W bits (top bits kept), then arithmetically right-shifted by the
// latched attenuation. Configuration is captured on leaving IDLE and again
// at every period wrap, so mid-period changes never glitch a period.
//
// Parameters:
//   DATA_W   output sample width (8..16)
//   HOLD_W   width of hold_cycles
//   SHIFT_W  width of amp_shift
// Ports:
//   clk_tb        clock
//   reset_tb      asynchronous active-high reset
//   en            level-sensitive run request
//   mode          waveform select: 0 sine, 1 square, 2 triangle, 3 sawtooth
//   hold_cycles   minimum cycles between sample loads, minus one
//   amp_shift     attenuation shift; values >= DATA_W act as DATA_W-1
//   dc_offset     (only with WAVE_STIM_DC_OFFSET_EN) signed offset, saturating
//   sample_ready  consumer accepts the offered sample
//   sample_out    signed sample, stable while sample_valid is high
//   sample_valid  sample_out holds an unaccepted sample
//   period_start  one-cycle pulse when a phase-0 sample is loaded
//   busy          FSM not in IDLE
//
// Build option: define WAVE_STIM_DC_OFFSET_EN to add the dc_offset input and
// the saturating offset adder. Without it there is no port and no adder.
// -----------------------------------------------------------------------------
module wave_stim_gen
  import wave_stim_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int HOLD_W  = 4,
  parameter int SHIFT_W = 4
) (
  input  logic                     clk_tb,
  input  logic                     reset_tb,
  input  logic                     en,
  input  logic [1:0]               mode,
  input  logic [HOLD_W-1:0]        hold_cycles,
  input  logic [SHIFT_W-1:0]       amp_shift,
`ifdef WAVE_STIM_DC_OFFSET_EN
  input  logic signed [DATA_W-1:0] dc_offset,
`endif
  input  logic                     sample_ready,
  output logic signed [DATA_W-1:0] sample_out,
  output logic                     sample_valid,
  output logic                     period_start,
  output logic                     busy
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                    state_q;
  logic [PHASE_W-1:0]        phase_q;
  logic [HOLD_W-1:0]         hold_cnt_q;
  logic [1:0]                mode_q;
  logic [HOLD_W-1:0]         hold_q;
  logic [SHIFT_W-1:0]        shift_q;
  logic signed [DATA_W-1:0]  out_q;
  logic                      valid_q;
  logic                      pstart_q;
`ifdef WAVE_STIM_DC_OFFSET_EN
  logic signed [DATA_W-1:0]  offset_q;
`endif

  assign sample_out   = out_q;
  assign sample_valid = valid_q;
  assign period_start = pstart_q;
  assign busy         = (state_q != IDLE);

  // ---------------------------------------------------------------------------
  // Next-sample datapath
  // ---------------------------------------------------------------------------
  // The next load uses freshly sampled configuration when it starts a period
  // (leaving IDLE, or wrapping 7 -> 0); otherwise the latched copy.
  logic                     start_cfg_d;
  logic [1:0]               sel_mode_d;
  logic [SHIFT_W-1:0]       sel_shift_d;
  logic [PHASE_W-1:0]       sel_phase_d;
  logic [TBL_W-1:0]         lut_val;
  logic signed [TBL_W-1:0]  tbl_s;
  logic [4:0]               shift_amt_d;
  logic signed [DATA_W-1:0] shifted_d;
  logic signed [DATA_W-1:0] sample_d;
  int                       shift_req;

  assign start_cfg_d = (state_q == IDLE) || (phase_q == PHASE_W'(STEPS - 1));
  assign sel_mode_d  = start_cfg_d ? mode      : mode_q;
  assign sel_shift_d = start_cfg_d ? amp_shift : shift_q;
  assign sel_phase_d = (state_q == IDLE) ? '0 : phase_q + 1'b1;

  wave_stim_lut u_lut (
    .mode_i  (sel_mode_d),
    .phase_i (sel_phase_d),
    .value_o (lut_val)
  );

  assign tbl_s = lut_val;

  always_comb begin
    shift_req   = int'(sel_shift_d);
    shift_amt_d = (shift_req >= DATA_W) ? 5'(DATA_W - 1) : 5'(shift_req);
    // Narrowing to DATA_W (keep top bits) and attenuation fold into a single
    // arithmetic shift of the 16-bit table value; the low DATA_W bits of the
    // result are exactly (top bits) >>> shift.
    shifted_d   = DATA_W'((tbl_s >>> (TBL_W - DATA_W)) >>> shift_amt_d);
  end

`ifdef WAVE_STIM_DC_OFFSET_EN
  logic signed [DATA_W-1:0] sel_offset_d;
  logic signed [DATA_W:0]   sum_d;

  assign sel_offset_d = start_cfg_d ? dc_offset : offset_q;

  always_comb begin
    sum_d = {shifted_d[DATA_W-1], shifted_d} + {sel_offset_d[DATA_W-1], sel_offset_d};
    // Overflow shows as a disagreement between the guard bit and the MSB.
    if (sum_d[DATA_W] != sum_d[DATA_W-1]) begin
      sample_d = sum_d[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                               : {1'b0, {(DATA_W-1){1'b1}}};
    end else begin
      sample_d = sum_d[DATA_W-1:0];
    end
  end
`else
  assign sample_d = shifted_d;
`endif

  // A load may happen once the hold has expired and the current sample is no
  // longer pending (never offered, already taken, or being taken now).
  logic load_point_d;
  assign load_point_d = (hold_cnt_q == hold_q) && (!valid_q || sample_ready);

  // ---------------------------------------------------------------------------
  // FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_tb or posedge reset_tb) begin
    if (reset_tb) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      hold_cnt_q <= '0;
      mode_q     <= '0;
      hold_q     <= '0;
      shift_q    <= '0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      pstart_q   <= 1'b0;
`ifdef WAVE_STIM_DC_OFFSET_EN
      offset_q   <= '0;
`endif
    end else begin
      pstart_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (en) begin
            mode_q     <= mode;
            hold_q     <= hold_cycles;
            shift_q    <= amp_shift;
`ifdef WAVE_STIM_DC_OFFSET_EN
            offset_q   <= dc_offset;
`endif
            phase_q    <= '0;
            out_q      <= sample_d;
            valid_q    <= 1'b1;
            pstart_q   <= 1'b1;
            hold_cnt_q <= '0;
            state_q    <= RUN;
          end
        end

        RUN: begin
          if (load_point_d) begin
            if (en) begin
              phase_q    <= sel_phase_d;
              out_q      <= sample_d;
              valid_q    <= 1'b1;
              hold_cnt_q <= '0;
              if (start_cfg_d) begin
                mode_q   <= mode;
                hold_q   <= hold_cycles;
                shift_q  <= amp_shift;
`ifdef WAVE_STIM_DC_OFFSET_EN
                offset_q <= dc_offset;
`endif
                pstart_q <= 1'b1;
              end
            end else begin
              // Last sample has been taken; wind down without a new load.
              valid_q <= 1'b0;
              state_q <= STOP;
            end
          end else begin
            if (hold_cnt_q != hold_q) begin
              hold_cnt_q <= hold_cnt_q + 1'b1;
            end
            if (valid_q && sample_ready) begin
              valid_q <= 1'b0;
            end
          end
        end

        STOP: begin
          out_q      <= '0;
          valid_q    <= 1'b0;
          phase_q    <= '0;
          hold_cnt_q <= '0;
          state_q    <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wave_stim_gen.sv
// -----------------------------------------------------------------------------
// tb_wave_stim_gen
// Directed bench for wave_stim_gen: a 16-bit and a 12-bit instance share the
// clock, reset and configuration inputs but have separate run requests.
// -----------------------------------------------------------------------------
module tb_wave_stim_gen;

  logic        clk_tb = 1'b0;
  logic        reset_tb;
  logic        en16, en12;
  logic [1:0]  mode;
  logic [3:0]  hold_cycles;
  logic [3:0]  amp_shift;
  logic        sample_ready;
`ifdef WAVE_STIM_DC_OFFSET_EN
  logic [15:0] dc16;
  logic [11:0] dc12;
`endif

  logic [15:0] out16;
  logic        v16, ps16, b16;
  logic [11:0] out12;
  logic        v12, ps12, b12;

  always #5 clk_tb = ~clk_tb;

  wave_stim_gen #(.DATA_W(16), .HOLD_W(4), .SHIFT_W(4)) dut16 (
    .clk_tb       (clk_tb),
    .reset_tb     (reset_tb),
    .en           (en16),
    .mode         (mode),
    .hold_cycles  (hold_cycles),
    .amp_shift    (amp_shift),
`ifdef WAVE_STIM_DC_OFFSET_EN
    .dc_offset    (dc16),
`endif
    .sample_ready (sample_ready),
    .sample_out   (out16),
    .sample_valid (v16),
    .period_start (ps16),
    .busy         (b16)
  );

  wave_stim_gen #(.DATA_W(12), .HOLD_W(4), .SHIFT_W(4)) dut12 (
    .clk_tb       (clk_tb),
    .reset_tb     (reset_tb),
    .en           (en12),
    .mode         (mode),
    .hold_cycles  (hold_cycles),
    .amp_shift    (amp_shift),
`ifdef WAVE_STIM_DC_OFFSET_EN
    .dc_offset    (dc12),
`endif
    .sample_ready (sample_ready),
    .sample_out   (out12),
    .sample_valid (v12),
    .period_start (ps12),
    .busy         (b12)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h", name, got, exp);
  endtask

  task automatic apply_reset();
    reset_tb     = 1'b1;
    en16         = 1'b0;
    en12         = 1'b0;
    sample_ready = 1'b1;
    mode         = 2'd0;
    hold_cycles  = 4'd0;
    amp_shift    = 4'd0;
`ifdef WAVE_STIM_DC_OFFSET_EN
    dc16         = 16'h0000;
    dc12         = 12'h000;
`endif
    repeat (2) @(negedge clk_tb);
    reset_tb = 1'b0;
    @(negedge clk_tb);
  endtask

  typedef struct {
    bit                   use12;
    logic [1:0]           mode;
    int                   hold;
    logic [3:0]           shift;
    logic [0:7][15:0]     exp;
  } vec_t;

  vec_t vecs [6];

  logic [15:0] g_out;
  logic        g_v, g_ps, g_b;

  initial begin
    int h, k;
    logic [15:0] exp3 [10];
    logic [15:0] exp6 [8];

    vecs[0] = '{1'b0, 2'd0, 3, 4'd0, {16'h0000, 16'h5A7E, 16'h7FFF, 16'h5A7E,
                                       16'h0000, 16'hA582, 16'h8000, 16'hA582}};
    vecs[1] = '{1'b0, 2'd1, 0, 4'd0, {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
                                       16'h8000, 16'h8000, 16'h8000, 16'h8000}};
    vecs[2] = '{1'b0, 2'd2, 1, 4'd1, {16'h0000, 16'h2000, 16'h3FFF, 16'h2000,
                                       16'h0000, 16'hE000, 16'hC000, 16'hE000}};
    vecs[3] = '{1'b0, 2'd3, 0, 4'd15, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                                        16'h0000, 16'h0000, 16'h0000, 16'h0000}};
    vecs[4] = '{1'b1, 2'd2, 0, 4'd0, {16'h0000, 16'h0400, 16'h07FF, 16'h0400,
                                       16'h0000, 16'h0C00, 16'h0800, 16'h0C00}};
    vecs[5] = '{1'b1, 2'd0, 2, 4'd13, {16'h0000, 16'h0000, 16'h0000, 16'h0000,
                                        16'h0000, 16'h0FFF, 16'h0FFF, 16'h0FFF}};

    // ---------------- reset state ----------------
    reset_tb = 1'b1; en16 = 1'b0; en12 = 1'b0; sample_ready = 1'b1;
    mode = 2'd0; hold_cycles = 4'd0; amp_shift = 4'd0;
`ifdef WAVE_STIM_DC_OFFSET_EN
    dc16 = 16'h0; dc12 = 12'h0;
`endif
    repeat (3) @(negedge clk_tb);
    chk("rst.out16",   32'(out16), 32'h0);
    chk("rst.valid16", 32'(v16),   32'h0);
    chk("rst.pstart16",32'(ps16),  32'h0);
    chk("rst.busy16",  32'(b16),   32'h0);
    chk("rst.out12",   32'(out12), 32'h0);
    chk("rst.valid12", 32'(v12),   32'h0);
    chk("rst.busy12",  32'(b12),   32'h0);
    $display("reset: outputs sampled while reset_tb high");

    // ---------------- table-driven full periods ----------------
    for (int i = 0; i < 6; i++) begin
      apply_reset();
      h            = vecs[i].hold;
      mode         = vecs[i].mode;
      hold_cycles  = 4'(h);
      amp_shift    = vecs[i].shift;
      sample_ready = 1'b1;
      if (vecs[i].use12) en12 = 1'b1;
      else               en16 = 1'b1;
      for (int c = 0; c <= 8 * (h + 1); c++) begin
        @(negedge clk_tb);
        g_out = vecs[i].use12 ? {4'h0, out12} : out16;
        g_v   = vecs[i].use12 ? v12  : v16;
        g_ps  = vecs[i].use12 ? ps12 : ps16;
        g_b   = vecs[i].use12 ? b12  : b16;
        if (c % (h + 1) == 0) begin
          k = (c / (h + 1)) % 8;
          chk($sformatf("v%0d.c%0d.sample", i, c), 32'(g_out), 32'(vecs[i].exp[k]));
          chk($sformatf("v%0d.c%0d.valid",  i, c), 32'(g_v),   32'h1);
          chk($sformatf("v%0d.c%0d.pstart", i, c), 32'(g_ps),  (k == 0) ? 32'h1 : 32'h0);
          chk($sformatf("v%0d.c%0d.busy",   i, c), 32'(g_b),   32'h1);
        end else if (c % (h + 1) == 1) begin
          chk($sformatf("v%0d.c%0d.valid_low", i, c), 32'(g_v),  32'h0);
          chk($sformatf("v%0d.c%0d.pstart_low", i, c), 32'(g_ps), 32'h0);
        end
      end
      en16 = 1'b0;
      en12 = 1'b0;
      $display("vector %0d: dw=%0d mode=%0d hold=%0d shift=%0d period checked",
               i, vecs[i].use12 ? 12 : 16, vecs[i].mode, h, vecs[i].shift);
    end

    // ---------------- back-pressure on triangle ----------------
    apply_reset();
    mode = 2'd2; hold_cycles = 4'd0; amp_shift = 4'd0; en16 = 1'b1;
    @(negedge clk_tb); chk("bp.ph0", 32'(out16), 32'h0000);
    @(negedge clk_tb); chk("bp.ph1", 32'(out16), 32'h4000);
    @(negedge clk_tb); chk("bp.ph2", 32'(out16), 32'h7FFF);
    sample_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk_tb);
      chk($sformatf("bp.stall%0d.sample", s), 32'(out16), 32'h7FFF);
      chk($sformatf("bp.stall%0d.valid",  s), 32'(v16),   32'h1);
    end
    sample_ready = 1'b1;
    @(negedge clk_tb); chk("bp.ph3", 32'(out16), 32'h4000); chk("bp.ph3.valid", 32'(v16), 32'h1);
    @(negedge clk_tb); chk("bp.ph4", 32'(out16), 32'h0000);
    @(negedge clk_tb); chk("bp.ph5", 32'(out16), 32'hC000);
    en16 = 1'b0;
    $display("backpressure: 5-cycle stall at phase 2 checked");

    // ---------------- 12-bit sawtooth, mid-period shift change ----------------
    apply_reset();
    exp3 = '{16'h0E00, 16'h0E80, 16'h0F00, 16'h0F80, 16'h0000,
             16'h0080, 16'h0100, 16'h0180, 16'h0800, 16'h0A00};
    mode = 2'd3; hold_cycles = 4'd0; amp_shift = 4'd2; en12 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_tb);
      chk($sformatf("saw12.c%0d", c), 32'({4'h0, out12}), 32'(exp3[c]));
      if (c == 0 || c == 8) chk($sformatf("saw12.c%0d.pstart", c), 32'(ps12), 32'h1);
      if (c == 2) amp_shift = 4'd0;
    end
    en12 = 1'b0;
    $display("saw12: shift change applied at next period start");

    // ---------------- stop sequence ----------------
    apply_reset();
    mode = 2'd1; hold_cycles = 4'd3; amp_shift = 4'd0; sample_ready = 1'b1; en16 = 1'b1;
    repeat (17) @(negedge clk_tb);
    chk("stop.ph4.sample", 32'(out16), 32'h8000);
    chk("stop.ph4.valid",  32'(v16),   32'h1);
    en16 = 1'b0;
    @(negedge clk_tb);
    chk("stop.taken.valid", 32'(v16), 32'h0);
    chk("stop.taken.busy",  32'(b16), 32'h1);
    repeat (2) @(negedge clk_tb);
    chk("stop.held.sample", 32'(out16), 32'h8000);
    @(negedge clk_tb);
    chk("stop.stop.sample", 32'(out16), 32'h8000);
    chk("stop.stop.valid",  32'(v16),   32'h0);
    chk("stop.stop.busy",   32'(b16),   32'h1);
    @(negedge clk_tb);
    chk("stop.idle.sample", 32'(out16), 32'h0);
    chk("stop.idle.valid",  32'(v16),   32'h0);
    chk("stop.idle.busy",   32'(b16),   32'h0);
    repeat (3) @(negedge clk_tb);
    chk("stop.idle_stays.busy", 32'(b16), 32'h0);
    $display("stop: phase-4 sample completed, STOP then IDLE");

    // ---------------- asynchronous reset mid-hold ----------------
    apply_reset();
    mode = 2'd0; hold_cycles = 4'd3; amp_shift = 4'd0; en16 = 1'b1;
    repeat (5) @(negedge clk_tb);
    chk("areset.pre.sample", 32'(out16), 32'h5A7E);
    chk("areset.pre.busy",   32'(b16),   32'h1);
    #2 reset_tb = 1'b1;
    #1;
    chk("areset.sample", 32'(out16), 32'h0);
    chk("areset.valid",  32'(v16),   32'h0);
    chk("areset.busy",   32'(b16),   32'h0);
    chk("areset.pstart", 32'(ps16),  32'h0);
    en16 = 1'b0;
    @(negedge clk_tb);
    reset_tb = 1'b0;
    $display("async reset: outputs cleared between clock edges");

`ifdef WAVE_STIM_DC_OFFSET_EN
    // ---------------- DC offset with saturation ----------------
    apply_reset();
    exp6 = '{16'h4000, 16'h7FFF, 16'h7FFF, 16'h7FFF,
             16'h4000, 16'hE582, 16'hC000, 16'hE582};
    mode = 2'd0; hold_cycles = 4'd0; amp_shift = 4'd0; dc16 = 16'h4000; en16 = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_tb);
      chk($sformatf("dc.ph%0d", c), 32'(out16), 32'(exp6[c]));
    end
    en16 = 1'b0;
    $display("dc offset: sine + 0x4000 saturation checked");
`endif

    repeat (4) @(negedge clk_tb);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
